// File: rtl/i2c_slave_byte_ctrl.sv
// i2c_slave_byte_ctrl
// Byte-level I2C target controller. SCL/SDA are oversampled on Clk and turned
// into edge strobes. A single FSM handles the address phase, write bytes with
// ACK, read bytes with master ACK/NACK, and START/STOP/repeated START. SDA is
// only ever pulled low (open drain) through Sda_oe. All outputs are registered.

module i2c_slave_byte_ctrl #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Scl_i,
  input  logic       Sda_i,
  output logic       Sda_oe,
  output logic [7:0] Rx_data,
  output logic       Rx_valid,
  input  logic [7:0] Tx_data,
  output logic       Tx_req,
  output logic       Addr_match,
  output logic       Rd_wr,
  output logic       Master_nack,
  output logic       Start_det,
  output logic       Stop_det,
  output logic       Busy
);

  // A single synchronizer flop is not safe against metastability.
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_WR_DATA   = 4'd3,
    ST_WR_ACK    = 4'd4,
    ST_RD_DATA   = 4'd5,
    ST_RD_ACK    = 4'd6,
    ST_RD_LOAD   = 4'd7,
    ST_WAIT_STOP = 4'd8
  } state_e;

  // True when the received address byte selects this target (bit 0 is R/W).
  function automatic logic addr_hit(input logic [7:0] addr_byte);
    return (addr_byte[7:1] == SLAVE_ADDR);
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge strobes
  // ---------------------------------------------------------------------------
  logic [SYNC_N-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_N-1:0] sda_sync_q, sda_sync_d;
  logic              scl_hist_q, scl_hist_d;
  logic              sda_hist_q, sda_hist_d;

  logic scl_s, sda_s;
  logic scl_rise_s, scl_fall_s, sda_rise_s, sda_fall_s;
  logic start_cond_s, stop_cond_s;

  // Next value of the synchronizer chains and the one-cycle history flops.
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_N-2:0], Scl_i};
    sda_sync_d = {sda_sync_q[SYNC_N-2:0], Sda_i};
    scl_hist_d = scl_sync_q[SYNC_N-1];
    sda_hist_d = sda_sync_q[SYNC_N-1];
  end

  // Synchronizer registers; reset to the idle-bus level so leaving reset never
  // fabricates an edge on a quiet bus.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      scl_sync_q <= {SYNC_N{1'b1}};
      sda_sync_q <= {SYNC_N{1'b1}};
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
    end
  end

  assign scl_s        = scl_sync_q[SYNC_N-1];
  assign sda_s        = sda_sync_q[SYNC_N-1];
  assign scl_rise_s   = scl_s & ~scl_hist_q;
  assign scl_fall_s   = ~scl_s & scl_hist_q;
  assign sda_rise_s   = sda_s & ~sda_hist_q;
  assign sda_fall_s   = ~sda_s & sda_hist_q;
  // SDA may only move while SCL is high to signal bus conditions.
  assign start_cond_s = sda_fall_s & scl_s;
  assign stop_cond_s  = sda_rise_s & scl_s;

  // ---------------------------------------------------------------------------
  // Protocol FSM and datapath
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        sda_oe_q, sda_oe_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rd_wr_q, rd_wr_d;
  logic        busy_q, busy_d;
  logic        rx_valid_q, rx_valid_d;
  logic        tx_req_q, tx_req_d;
  logic        addr_match_q, addr_match_d;
  logic        master_nack_q, master_nack_d;
  logic        start_det_q, start_det_d;
  logic        stop_det_q, stop_det_d;
  logic [7:0]  rx_byte_s;

  // Byte as it stands once the bit sampled on this scl_rise is shifted in.
  assign rx_byte_s = {shift_q[6:0], sda_s};

  // Next-state and output logic; bus conditions override all bit-level work.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    sda_oe_d      = sda_oe_q;
    rx_data_d     = rx_data_q;
    rd_wr_d       = rd_wr_q;
    busy_d        = busy_q;
    rx_valid_d    = 1'b0;
    tx_req_d      = 1'b0;
    addr_match_d  = 1'b0;
    master_nack_d = 1'b0;
    start_det_d   = 1'b0;
    stop_det_d    = 1'b0;

    if (start_cond_s) begin
      start_det_d = 1'b1;
      busy_d      = 1'b1;
      sda_oe_d    = 1'b0;
      bit_cnt_d   = 3'd0;
      state_d     = ST_ADDR;
    end else if (stop_cond_s) begin
      // Any partially shifted byte is simply dropped.
      stop_det_d = 1'b1;
      busy_d     = 1'b0;
      sda_oe_d   = 1'b0;
      bit_cnt_d  = 3'd0;
      state_d    = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sda_oe_d = 1'b0;
        end

        ST_ADDR: begin
          if (scl_rise_s) begin
            shift_d   = rx_byte_s;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (addr_hit(rx_byte_s)) begin
                addr_match_d = 1'b1;
                rd_wr_d      = rx_byte_s[0];
                state_d      = ST_ADDR_ACK;
              end else begin
                state_d = ST_WAIT_STOP;
              end
            end else begin
              state_d = ST_ADDR;
            end
          end else begin
            state_d = ST_ADDR;
          end
        end

        // Sda_oe doubles as the phase flag: low = before the ACK slot,
        // high = inside the ACK slot.
        ST_ADDR_ACK: begin
          if (scl_fall_s) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (rd_wr_q) begin
              shift_d   = Tx_data;
              sda_oe_d  = ~Tx_data[7];
              bit_cnt_d = 3'd0;
              state_d   = ST_RD_DATA;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
              state_d   = ST_WR_DATA;
            end
          end else if (scl_rise_s) begin
            if (sda_oe_q && rd_wr_q) begin
              tx_req_d = 1'b1;
            end else begin
              tx_req_d = 1'b0;
            end
          end else begin
            state_d = ST_ADDR_ACK;
          end
        end

        ST_WR_DATA: begin
          if (scl_rise_s) begin
            shift_d   = rx_byte_s;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d  = rx_byte_s;
              rx_valid_d = 1'b1;
              state_d    = ST_WR_ACK;
            end else begin
              state_d = ST_WR_DATA;
            end
          end else begin
            state_d = ST_WR_DATA;
          end
        end

        // Writes are always acknowledged; same Sda_oe phase trick as above.
        ST_WR_ACK: begin
          if (scl_fall_s) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
              state_d   = ST_WR_DATA;
            end
          end else begin
            state_d = ST_WR_ACK;
          end
        end

        // bit_cnt counts bits already driven; bit 7 went out on entry.
        ST_RD_DATA: begin
          if (scl_fall_s) begin
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
              state_d   = ST_RD_ACK;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            state_d = ST_RD_DATA;
          end
        end

        ST_RD_ACK: begin
          if (scl_rise_s) begin
            if (!sda_s) begin
              tx_req_d = 1'b1;
              state_d  = ST_RD_LOAD;
            end else begin
              master_nack_d = 1'b1;
              sda_oe_d      = 1'b0;
              state_d       = ST_WAIT_STOP;
            end
          end else begin
            state_d = ST_RD_ACK;
          end
        end

        // Host has had half an SCL period since Tx_req to present Tx_data.
        ST_RD_LOAD: begin
          if (scl_fall_s) begin
            shift_d   = Tx_data;
            sda_oe_d  = ~Tx_data[7];
            bit_cnt_d = 3'd0;
            state_d   = ST_RD_DATA;
          end else begin
            state_d = ST_RD_LOAD;
          end
        end

        ST_WAIT_STOP: begin
          sda_oe_d = 1'b0;
        end

        default: begin
          sda_oe_d  = 1'b0;
          bit_cnt_d = 3'd0;
          state_d   = ST_IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered output flops.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'h00;
      sda_oe_q      <= 1'b0;
      rx_data_q     <= 8'h00;
      rd_wr_q       <= 1'b0;
      busy_q        <= 1'b0;
      rx_valid_q    <= 1'b0;
      tx_req_q      <= 1'b0;
      addr_match_q  <= 1'b0;
      master_nack_q <= 1'b0;
      start_det_q   <= 1'b0;
      stop_det_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      sda_oe_q      <= sda_oe_d;
      rx_data_q     <= rx_data_d;
      rd_wr_q       <= rd_wr_d;
      busy_q        <= busy_d;
      rx_valid_q    <= rx_valid_d;
      tx_req_q      <= tx_req_d;
      addr_match_q  <= addr_match_d;
      master_nack_q <= master_nack_d;
      start_det_q   <= start_det_d;
      stop_det_q    <= stop_det_d;
    end
  end

  assign Sda_oe      = sda_oe_q;
  assign Rx_data     = rx_data_q;
  assign Rx_valid    = rx_valid_q;
  assign Tx_req      = tx_req_q;
  assign Addr_match  = addr_match_q;
  assign Rd_wr       = rd_wr_q;
  assign Master_nack = master_nack_q;
  assign Start_det   = start_det_q;
  assign Stop_det    = stop_det_q;
  assign Busy        = busy_q;

endmodule

// File: tb/tb_i2c_slave_byte_ctrl.sv
// Directed bench for i2c_slave_byte_ctrl: a behavioural I2C master drives
// SCL/SDA (SCL half period 20 Clk), the pad wire-ANDs master SDA with the
// target's open-drain pull-down, and a negedge monitor counts output pulses.

module tb_i2c_slave_byte_ctrl;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] Tx_data = 8'h00;
  logic       sda_pad;
  logic       Sda_oe, Rx_valid, Tx_req, Addr_match, Rd_wr;
  logic       Master_nack, Start_det, Stop_det, Busy;
  logic [7:0] Rx_data;

  int n_pass = 0;
  int n_chk  = 0;

  int c_start = 0, c_stop = 0, c_match = 0, c_rxv = 0;
  int c_txreq = 0, c_nack = 0, c_oe = 0, c_viol = 0;
  logic [7:0] last_rx = 8'h00;
  logic       prev_oe = 1'b0;

  assign sda_pad = sda_m & ~Sda_oe;

  always #5 Clk = ~Clk;

  i2c_slave_byte_ctrl #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .Clk(Clk), .Rst(Rst), .Scl_i(scl_m), .Sda_i(sda_pad), .Sda_oe(Sda_oe),
    .Rx_data(Rx_data), .Rx_valid(Rx_valid), .Tx_data(Tx_data), .Tx_req(Tx_req),
    .Addr_match(Addr_match), .Rd_wr(Rd_wr), .Master_nack(Master_nack),
    .Start_det(Start_det), .Stop_det(Stop_det), .Busy(Busy)
  );

  // Pulse counters and open-drain timing watch, sampled away from posedge.
  always @(negedge Clk) begin
    if (Start_det)   c_start++;
    if (Stop_det)    c_stop++;
    if (Addr_match)  c_match++;
    if (Tx_req)      c_txreq++;
    if (Master_nack) c_nack++;
    if (Sda_oe)      c_oe++;
    if (Rx_valid) begin
      c_rxv++;
      last_rx = Rx_data;
    end
    if (!Rst && (Sda_oe !== prev_oe) && scl_m) c_viol++;
    prev_oe = Sda_oe;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // One SCL clock; returns the pad SDA level sampled mid-high.
  task automatic send_bit(input logic b, output logic s);
    tick(10); sda_m = b;
    tick(10); scl_m = 1'b1;
    tick(10); s = sda_pad;
    tick(10); scl_m = 1'b0;
  endtask

  task automatic do_start();
    sda_m = 1'b1; tick(10);
    scl_m = 1'b1; tick(10);
    sda_m = 1'b0; tick(10);
    scl_m = 1'b0; tick(10);
  endtask

  task automatic do_stop();
    sda_m = 1'b0; tick(10);
    scl_m = 1'b1; tick(10);
    sda_m = 1'b1; tick(10);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(d[i], s);
    send_bit(1'b1, s);
    ack = ~s;
  endtask

  // Reads a byte; next_tx is presented before the ACK slot for a following byte.
  task automatic recv_byte(input logic mack, input logic [7:0] next_tx, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      d[i] = s;
    end
    Tx_data = next_tx;
    send_bit(~mack, s);
  endtask

  task automatic test_reset();
    Rst = 1'b1; tick(5);
    Rst = 1'b0; tick(5);
    n_chk++; if (Sda_oe !== 1'b0) $display("FAIL rst_oe: got %b want 0", Sda_oe); else n_pass++;
    n_chk++; if (Busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", Busy); else n_pass++;
    n_chk++; if (Rx_data !== 8'h00) $display("FAIL rst_rxdata: got %h want 00", Rx_data); else n_pass++;
    n_chk++; if (Rd_wr !== 1'b0) $display("FAIL rst_rdwr: got %b want 0", Rd_wr); else n_pass++;
    n_chk++;
    if ({Rx_valid, Tx_req, Addr_match, Master_nack, Start_det, Stop_det} !== 6'b000000)
      $display("FAIL rst_pulses: got %b want 000000",
               {Rx_valid, Tx_req, Addr_match, Master_nack, Start_det, Stop_det});
    else n_pass++;
    n_chk++; if (c_start + c_stop !== 0) $display("FAIL rst_no_events: got %0d want 0", c_start + c_stop); else n_pass++;
  endtask

  task automatic test_write();
    logic ack;
    int b_match = c_match, b_rxv = c_rxv, b_stop = c_stop;
    do_start();
    n_chk++; if (Busy !== 1'b1) $display("FAIL wr_busy: got %b want 1", Busy); else n_pass++;
    send_byte(8'hA0, ack);
    n_chk++; if (ack !== 1'b1) $display("FAIL wr_addr_ack: got %b want 1", ack); else n_pass++;
    n_chk++; if (c_match - b_match !== 1) $display("FAIL wr_match: got %0d want 1", c_match - b_match); else n_pass++;
    n_chk++; if (Rd_wr !== 1'b0) $display("FAIL wr_rdwr: got %b want 0", Rd_wr); else n_pass++;
    send_byte(8'h3C, ack);
    n_chk++; if (ack !== 1'b1) $display("FAIL wr_data_ack: got %b want 1", ack); else n_pass++;
    n_chk++; if (c_rxv - b_rxv !== 1) $display("FAIL wr_rxv: got %0d want 1", c_rxv - b_rxv); else n_pass++;
    n_chk++; if (last_rx !== 8'h3C) $display("FAIL wr_rxdata: got %h want 3c", last_rx); else n_pass++;
    do_stop();
    n_chk++; if (c_stop - b_stop !== 1) $display("FAIL wr_stop: got %0d want 1", c_stop - b_stop); else n_pass++;
    n_chk++; if (Busy !== 1'b0) $display("FAIL wr_busy_end: got %b want 0", Busy); else n_pass++;
  endtask

  task automatic test_read_one();
    logic ack;
    logic [7:0] d;
    int b_txreq = c_txreq, b_nack = c_nack;
    Tx_data = 8'h96;
    do_start();
    send_byte(8'hA1, ack);
    n_chk++; if (ack !== 1'b1) $display("FAIL rd1_addr_ack: got %b want 1", ack); else n_pass++;
    n_chk++; if (Rd_wr !== 1'b1) $display("FAIL rd1_rdwr: got %b want 1", Rd_wr); else n_pass++;
    recv_byte(1'b0, 8'h00, d);
    n_chk++; if (d !== 8'h96) $display("FAIL rd1_byte: got %h want 96", d); else n_pass++;
    n_chk++; if (c_txreq - b_txreq !== 1) $display("FAIL rd1_txreq: got %0d want 1", c_txreq - b_txreq); else n_pass++;
    n_chk++; if (c_nack - b_nack !== 1) $display("FAIL rd1_nack: got %0d want 1", c_nack - b_nack); else n_pass++;
    tick(20);
    n_chk++; if (Sda_oe !== 1'b0) $display("FAIL rd1_released: got %b want 0", Sda_oe); else n_pass++;
    do_stop();
    n_chk++; if (Busy !== 1'b0) $display("FAIL rd1_busy_end: got %b want 0", Busy); else n_pass++;
  endtask

  task automatic test_read_two();
    logic ack;
    logic [7:0] d1, d2;
    int b_txreq = c_txreq, b_nack = c_nack;
    Tx_data = 8'hA5;
    do_start();
    send_byte(8'hA1, ack);
    recv_byte(1'b1, 8'h0F, d1);
    recv_byte(1'b0, 8'h00, d2);
    do_stop();
    n_chk++; if (d1 !== 8'hA5) $display("FAIL rd2_byte0: got %h want a5", d1); else n_pass++;
    n_chk++; if (d2 !== 8'h0F) $display("FAIL rd2_byte1: got %h want 0f", d2); else n_pass++;
    n_chk++; if (c_txreq - b_txreq !== 2) $display("FAIL rd2_txreq: got %0d want 2", c_txreq - b_txreq); else n_pass++;
    n_chk++; if (c_nack - b_nack !== 1) $display("FAIL rd2_nack: got %0d want 1", c_nack - b_nack); else n_pass++;
  endtask

  task automatic test_mismatch();
    logic ack1, ack2;
    int b_oe = c_oe, b_match = c_match, b_rxv = c_rxv;
    do_start();
    send_byte(8'hA4, ack1);
    send_byte(8'h55, ack2);
    n_chk++; if (ack1 !== 1'b0) $display("FAIL mis_addr_ack: got %b want 0", ack1); else n_pass++;
    n_chk++; if (ack2 !== 1'b0) $display("FAIL mis_data_ack: got %b want 0", ack2); else n_pass++;
    n_chk++; if (c_oe - b_oe !== 0) $display("FAIL mis_oe_cycles: got %0d want 0", c_oe - b_oe); else n_pass++;
    n_chk++; if (c_match - b_match !== 0) $display("FAIL mis_match: got %0d want 0", c_match - b_match); else n_pass++;
    n_chk++; if (c_rxv - b_rxv !== 0) $display("FAIL mis_rxv: got %0d want 0", c_rxv - b_rxv); else n_pass++;
    n_chk++; if (Busy !== 1'b1) $display("FAIL mis_busy: got %b want 1", Busy); else n_pass++;
    do_stop();
    n_chk++; if (Busy !== 1'b0) $display("FAIL mis_busy_end: got %b want 0", Busy); else n_pass++;
  endtask

  task automatic test_repeated_start();
    logic ack;
    logic [7:0] d;
    int b_start = c_start, b_rxv = c_rxv;
    Tx_data = 8'h77;
    do_start();
    send_byte(8'hA0, ack);
    send_byte(8'h12, ack);
    do_start();
    send_byte(8'hA1, ack);
    n_chk++; if (ack !== 1'b1) $display("FAIL sr_addr_ack: got %b want 1", ack); else n_pass++;
    n_chk++; if (Rd_wr !== 1'b1) $display("FAIL sr_rdwr: got %b want 1", Rd_wr); else n_pass++;
    recv_byte(1'b0, 8'h00, d);
    do_stop();
    n_chk++; if (c_start - b_start !== 2) $display("FAIL sr_starts: got %0d want 2", c_start - b_start); else n_pass++;
    n_chk++; if (Rx_data !== 8'h12) $display("FAIL sr_rxdata: got %h want 12", Rx_data); else n_pass++;
    n_chk++; if (c_rxv - b_rxv !== 1) $display("FAIL sr_rxv: got %0d want 1", c_rxv - b_rxv); else n_pass++;
    n_chk++; if (d !== 8'h77) $display("FAIL sr_byte: got %h want 77", d); else n_pass++;
  endtask

  task automatic test_abort_stop();
    logic ack, s;
    int b_rxv = c_rxv, b_stop = c_stop;
    do_start();
    send_byte(8'hA0, ack);
    send_bit(1'b1, s); send_bit(1'b0, s); send_bit(1'b1, s); send_bit(1'b1, s);
    do_stop();
    n_chk++; if (c_rxv - b_rxv !== 0) $display("FAIL abort_rxv: got %0d want 0", c_rxv - b_rxv); else n_pass++;
    n_chk++; if (c_stop - b_stop !== 1) $display("FAIL abort_stop: got %0d want 1", c_stop - b_stop); else n_pass++;
    n_chk++; if (Busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", Busy); else n_pass++;
    n_chk++; if (Rx_data !== 8'h12) $display("FAIL abort_rxdata: got %h want 12", Rx_data); else n_pass++;
  endtask

  task automatic test_abort_reset();
    logic ack;
    Tx_data = 8'h00;
    do_start();
    send_byte(8'hA1, ack);
    tick(6);
    n_chk++; if (Sda_oe !== 1'b1) $display("FAIL rrst_driving: got %b want 1", Sda_oe); else n_pass++;
    Rst = 1'b1; tick(1);
    n_chk++; if (Sda_oe !== 1'b0) $display("FAIL rrst_oe: got %b want 0", Sda_oe); else n_pass++;
    n_chk++; if (Busy !== 1'b0) $display("FAIL rrst_busy: got %b want 0", Busy); else n_pass++;
    Rst = 1'b0; tick(5);
    scl_m = 1'b1; tick(20);
    n_chk++; if (Busy !== 1'b0) $display("FAIL rrst_idle: got %b want 0", Busy); else n_pass++;
    n_chk++; if (c_viol !== 0) $display("FAIL oe_while_scl_high: got %0d want 0", c_viol); else n_pass++;
  endtask

  initial begin
    tick(1);
    test_reset();
    test_write();
    test_read_one();
    test_read_two();
    test_mismatch();
    test_repeated_start();
    test_abort_stop();
    test_abort_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
